// File: rtl/coffee_brew_ctrl_if.sv
// Handshake bundle between the vending controller and the coffee brewing stage.
// BREW_CNT_EN adds the 16-bit brew_count output to the bundle.
interface coffee_brew_ctrl_if;
    logic        prepare_coffee;
    logic        cup_present;
    logic        cup_drop;
    logic        grinder_on;
    logic        heater_on;
    logic        pump_on;
    logic        coffee_ready;
    logic        busy;
    logic        fault;
`ifdef BREW_CNT_EN
    logic [15:0] brew_count;

    modport master (
        output prepare_coffee, cup_present,
        input  cup_drop, grinder_on, heater_on, pump_on,
        input  coffee_ready, busy, fault, brew_count
    );
    modport slave (
        input  prepare_coffee, cup_present,
        output cup_drop, grinder_on, heater_on, pump_on,
        output coffee_ready, busy, fault, brew_count
    );
`else
    modport master (
        output prepare_coffee, cup_present,
        input  cup_drop, grinder_on, heater_on, pump_on,
        input  coffee_ready, busy, fault
    );
    modport slave (
        input  prepare_coffee, cup_present,
        output cup_drop, grinder_on, heater_on, pump_on,
        output coffee_ready, busy, fault
    );
`endif
endinterface

// File: rtl/coffee_brew_ctrl.sv
// Brewing sequencer: cup drop, grind, heat, pour with cycle timers on clk4m.
// Optional BREW_CNT_EN adds a saturating count of completed brews.
module coffee_brew_ctrl #(
    parameter int unsigned CUP_TIMEOUT = 16,
    parameter int unsigned GRIND_CYC   = 8,
    parameter int unsigned HEAT_CYC    = 12,
    parameter int unsigned POUR_CYC    = 20
) (
    input  logic               clk4m,
    input  logic               rst,
    coffee_brew_ctrl_if.slave  bus
);

    localparam int unsigned MAX_AB = (CUP_TIMEOUT > GRIND_CYC) ? CUP_TIMEOUT : GRIND_CYC;
    localparam int unsigned MAX_CD = (HEAT_CYC > POUR_CYC) ? HEAT_CYC : POUR_CYC;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned TW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CUP   = 3'd1;
    localparam logic [2:0] S_GRIND = 3'd2;
    localparam logic [2:0] S_HEAT  = 3'd3;
    localparam logic [2:0] S_POUR  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          prev_q;
    logic          start;
    logic          cup_drop_q, grinder_q, heater_q, pump_q;
    logic          ready_q, busy_q, fault_q;

    assign start = bus.prepare_coffee & ~prev_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CUP;
                    timer_d = TW'(CUP_TIMEOUT - 1);
                end
            end
            S_CUP: begin
                // Cup arrival takes priority over a coincident timeout.
                if (bus.cup_present) begin
                    state_d = S_GRIND;
                    timer_d = TW'(GRIND_CYC - 1);
                end else if (timer_q == '0) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GRIND, S_HEAT, S_POUR: begin
                if (!bus.cup_present) begin
                    state_d = S_FAULT;
                    timer_d = '0;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (state_q == S_GRIND) begin
                    state_d = S_HEAT;
                    timer_d = TW'(HEAT_CYC - 1);
                end else if (state_q == S_HEAT) begin
                    state_d = S_POUR;
                    timer_d = TW'(POUR_CYC - 1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.cup_present) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (!bus.prepare_coffee && !bus.cup_present) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Request level is tracked through reset so a request held across reset is not a fresh edge.
    always_ff @(posedge clk4m) begin
        prev_q <= bus.prepare_coffee;
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            cup_drop_q <= 1'b0;
            grinder_q  <= 1'b0;
            heater_q   <= 1'b0;
            pump_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cup_drop_q <= (state_d == S_CUP) && (state_q != S_CUP);
            grinder_q  <= (state_d == S_GRIND);
            heater_q   <= (state_d == S_HEAT) || (state_d == S_POUR);
            pump_q     <= (state_d == S_POUR);
            ready_q    <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            fault_q    <= (state_d == S_FAULT);
        end
    end

    assign bus.cup_drop     = cup_drop_q;
    assign bus.grinder_on   = grinder_q;
    assign bus.heater_on    = heater_q;
    assign bus.pump_on      = pump_q;
    assign bus.coffee_ready = ready_q;
    assign bus.busy         = busy_q;
    assign bus.fault        = fault_q;

`ifdef BREW_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_DONE && !bus.cup_present && cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk4m) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.brew_count = cnt_q;
`endif

endmodule

// File: tb/tb_coffee_brew_ctrl.sv
// Self-checking bench for coffee_brew_ctrl: phase/elapsed-time reference model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_coffee_brew_ctrl;

    localparam int CUP_T = 16;
    localparam int GR_T  = 8;
    localparam int HT_T  = 12;
    localparam int PR_T  = 20;

    localparam int P_IDLE  = 0;
    localparam int P_CUP   = 1;
    localparam int P_GRIND = 2;
    localparam int P_HEAT  = 3;
    localparam int P_POUR  = 4;
    localparam int P_DONE  = 5;
    localparam int P_FAULT = 6;

    logic clk4m = 1'b0;
    logic rst   = 1'b1;

    coffee_brew_ctrl_if bus ();

    coffee_brew_ctrl #(
        .CUP_TIMEOUT(CUP_T),
        .GRIND_CYC  (GR_T),
        .HEAT_CYC   (HT_T),
        .POUR_CYC   (PR_T)
    ) dut (
        .clk4m(clk4m),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk4m = ~clk4m;

    int errors = 0;
    int checks = 0;

    // Reference model: current phase and cycles already spent in it.
    int m_ph   = P_IDLE;
    int m_e    = 0;
    bit m_prev = 1'b0;
    int m_cnt  = 0;

    // Observation counters for directed scenarios.
    int n_drop, n_grind, n_heat_only, n_pump, n_ready, n_fault, n_cup;

    function automatic int dur(input int ph);
        case (ph)
            P_GRIND: return GR_T;
            P_HEAT:  return HT_T;
            default: return PR_T;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit start;
        bit prep, cup;
        prep   = bus.prepare_coffee;
        cup    = bus.cup_present;
        start  = prep && !m_prev;
        m_prev = prep;
        if (rst) begin
            m_ph = P_IDLE; m_e = 0; m_cnt = 0;
            return;
        end
        case (m_ph)
            P_IDLE: if (start) begin m_ph = P_CUP; m_e = 0; end
            P_CUP: begin
                if (cup) begin m_ph = P_GRIND; m_e = 0; end
                else if (m_e == CUP_T - 1) begin m_ph = P_FAULT; m_e = 0; end
                else m_e++;
            end
            P_GRIND, P_HEAT, P_POUR: begin
                if (!cup) begin m_ph = P_FAULT; m_e = 0; end
                else if (m_e == dur(m_ph) - 1) begin m_ph = m_ph + 1; m_e = 0; end
                else m_e++;
            end
            P_DONE: if (!cup) begin
                m_ph = P_IDLE;
                if (m_cnt < 65535) m_cnt++;
            end
            default: if (!prep && !cup) m_ph = P_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("cup_drop",     16'(bus.cup_drop),     16'(m_ph == P_CUP && m_e == 0));
        check("grinder_on",   16'(bus.grinder_on),   16'(m_ph == P_GRIND));
        check("heater_on",    16'(bus.heater_on),    16'(m_ph == P_HEAT || m_ph == P_POUR));
        check("pump_on",      16'(bus.pump_on),      16'(m_ph == P_POUR));
        check("coffee_ready", 16'(bus.coffee_ready), 16'(m_ph == P_DONE));
        check("busy",         16'(bus.busy),         16'(m_ph != P_IDLE));
        check("fault",        16'(bus.fault),        16'(m_ph == P_FAULT));
`ifdef BREW_CNT_EN
        check("brew_count",   bus.brew_count,        16'(m_cnt));
`endif
    endtask

    task automatic clear_counts();
        n_drop = 0; n_grind = 0; n_heat_only = 0; n_pump = 0;
        n_ready = 0; n_fault = 0; n_cup = 0;
    endtask

    task automatic tick();
        @(posedge clk4m);
        model_step();
        #1;
        compare_all();
        n_drop      += int'(bus.cup_drop);
        n_grind     += int'(bus.grinder_on);
        n_heat_only += int'(bus.heater_on && !bus.pump_on);
        n_pump      += int'(bus.pump_on && bus.heater_on);
        n_ready     += int'(bus.coffee_ready);
        n_fault     += int'(bus.fault);
        n_cup       += int'(bus.busy && !bus.fault && !bus.grinder_on && !bus.heater_on && !bus.coffee_ready);
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return bus.coffee_ready;
            1:       return bus.fault;
            2:       return bus.pump_on;
            default: return bus.heater_on && !bus.pump_on;
        endcase
    endfunction

    task automatic run_until(input int what, input int budget, input string name);
        int k;
        k = 0;
        while (!cond(what) && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (!cond(what)) begin
            errors++;
            $display("FAIL %s: condition not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.prepare_coffee = 1'b1;
        bus.cup_present    = 1'b0;
        rst                = 1'b1;

        // Reset with request held high; no start afterwards without a new edge.
        ticks(2);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_drop", 16'(bus.cup_drop), 16'd0);
        rst = 1'b0;
        clear_counts();
        ticks(4);
        check("no_start_after_rst", 16'(n_drop + int'(bus.busy)), 16'd0);

        // Normal brew; cup arrives two cycles after cup_drop.
        bus.prepare_coffee = 1'b0;
        tick();
        clear_counts();
        bus.prepare_coffee = 1'b1;
        tick();
        check("drop_first_cycle", 16'(bus.cup_drop), 16'd1);
        tick();
        tick();
        bus.cup_present = 1'b1;
        run_until(0, 100, "wait_ready_1");
        check("n_drop",      16'(n_drop), 16'd1);
        check("n_grind",     16'(n_grind), 16'd8);
        check("n_heat_only", 16'(n_heat_only), 16'd12);
        check("n_pump",      16'(n_pump), 16'd20);
        tick();
        check("ready_held", 16'(bus.coffee_ready), 16'd1);
        bus.cup_present = 1'b0;
        tick();
        check("ready_clear", 16'(bus.coffee_ready), 16'd0);
        check("idle_after_take", 16'(bus.busy), 16'd0);

        // Cup never arrives.
        bus.prepare_coffee = 1'b0;
        tick();
        clear_counts();
        bus.prepare_coffee = 1'b1;
        run_until(1, 40, "wait_cup_timeout");
        check("cup_wait_len", 16'(n_cup), 16'd16);
        check("no_actuator_timeout", 16'(n_grind + n_heat_only + n_pump), 16'd0);
        tick();
        check("fault_held", 16'(bus.fault), 16'd1);
        bus.prepare_coffee = 1'b0;
        tick();
        check("fault_exit", 16'(bus.busy), 16'd0);

        // Cup removed during cycle 5 of POUR.
        bus.cup_present = 1'b1;
        tick();
        clear_counts();
        bus.prepare_coffee = 1'b1;
        run_until(2, 60, "wait_pour");
        ticks(4);
        bus.cup_present = 1'b0;
        tick();
        check("pour_abort_pump", 16'(bus.pump_on), 16'd0);
        check("pour_abort_heat", 16'(bus.heater_on), 16'd0);
        check("pour_abort_fault", 16'(bus.fault), 16'd1);
        check("pour_abort_no_ready", 16'(n_ready), 16'd0);
        bus.prepare_coffee = 1'b0;
        tick();

        // Request pulsed during HEAT and held through DONE.
        bus.cup_present = 1'b1;
        tick();
        clear_counts();
        bus.prepare_coffee = 1'b1;
        run_until(3, 60, "wait_heat");
        bus.prepare_coffee = 1'b0;
        tick();
        bus.prepare_coffee = 1'b1;
        tick();
        run_until(0, 100, "wait_ready_2");
        ticks(3);
        check("retrig_single_drop", 16'(n_drop), 16'd1);
        bus.cup_present = 1'b0;
        tick();
        clear_counts();
        ticks(3);
        check("no_retrigger_level", 16'(n_drop + int'(bus.busy)), 16'd0);

        // Third complete brew.
        bus.prepare_coffee = 1'b0;
        bus.cup_present    = 1'b1;
        tick();
        bus.prepare_coffee = 1'b1;
        run_until(0, 100, "wait_ready_3");
        bus.cup_present = 1'b0;
        tick();
        check("model_brews", 16'(m_cnt), 16'd3);
`ifdef BREW_CNT_EN
        check("brew_count_3", bus.brew_count, 16'd3);
`endif

        // Reset in the middle of POUR.
        bus.prepare_coffee = 1'b0;
        bus.cup_present    = 1'b1;
        tick();
        bus.prepare_coffee = 1'b1;
        run_until(2, 60, "wait_pour_rst");
        ticks(3);
        rst = 1'b1;
        tick();
        check("rst_pour_pump", 16'(bus.pump_on), 16'd0);
        check("rst_pour_busy", 16'(bus.busy), 16'd0);
`ifdef BREW_CNT_EN
        check("rst_brew_count", bus.brew_count, 16'd0);
`endif
        rst = 1'b0;

        // Randomized stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 29) == 0) bus.prepare_coffee = ~bus.prepare_coffee;
            if ($urandom_range(0, 59) == 0) bus.cup_present = ~bus.cup_present;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
